// File: rtl/pico_periph_bus_if.sv
`default_nettype none
// ============================================================================
//  Module   : pico_periph_bus_if
//  Purpose  : picorv32 native memory bus bundle (CPU request / response side).
//  Revision : 1.0  initial release
// ============================================================================
interface pico_periph_bus_if;
    logic        m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_ready;
    logic [31:0] m_rdata;

    modport master (
        output m_valid, m_addr, m_wdata, m_wstrb,
        input  m_ready, m_rdata
    );

    modport slave (
        input  m_valid, m_addr, m_wdata, m_wstrb,
        output m_ready, m_rdata
    );
endinterface
`default_nettype wire

// File: rtl/pico_periph_bus.sv
`default_nettype none
// ============================================================================
//  Module   : pico_periph_bus
//  Purpose  : Strided peripheral decoder for the picorv32 bus with per-slave
//             ready, watchdog timeout and sticky error logging.
//  Revision : 1.0  initial release
// ============================================================================
module pico_periph_bus #(
    parameter int          NUM_SLV   = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0001_8000,
    parameter logic [31:0] STRIDE    = 32'h10,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  wire logic                    clk,
    input  wire logic                    resetn,
    pico_periph_bus_if.slave             cpu,
    output logic [NUM_SLV-1:0]           s_sel,
    output logic [31:0]                  s_addr,
    output logic [31:0]                  s_wdata,
    output logic [3:0]                   s_wstrb,
    input  wire logic [NUM_SLV-1:0]      s_ready,
    input  wire logic [NUM_SLV*32-1:0]   s_rdata,
    input  wire logic                    err_clr,
    output logic                         err_flag,
    output logic [31:0]                  err_addr
);

    localparam int IDX_W     = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int CNT_W     = $clog2(TIMEOUT + 1);
    localparam int STRIDE_SH = $clog2(STRIDE);

    localparam logic [32:0]      WIN_SIZE = 33'(NUM_SLV) * {1'b0, STRIDE};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]       state_q,    state_d;
    logic [IDX_W-1:0] idx_q,      idx_d;
    logic [31:0]      addr_q,     addr_d;
    logic [31:0]      wdata_q,    wdata_d;
    logic [3:0]       wstrb_q,    wstrb_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [31:0]      rdata_q,    rdata_d;
    logic             err_flag_q, err_flag_d;
    logic [31:0]      err_addr_q, err_addr_d;

    logic [31:0]      w_offset;
    logic             w_in_win;
    logic             w_aligned;
    logic [IDX_W-1:0] w_idx;
    logic             w_sel_ready;
    logic [31:0]      w_sel_rdata;
    logic             w_err_set;

    // 33-bit compare keeps the window check correct even near the top of memory
    assign w_offset    = cpu.m_addr - BASE_ADDR;
    assign w_in_win    = (cpu.m_addr >= BASE_ADDR) && ({1'b0, w_offset} < WIN_SIZE);
    assign w_aligned   = (w_offset & (STRIDE - 32'd1)) == 32'd0;
    assign w_idx       = IDX_W'(w_offset >> STRIDE_SH);
    assign w_sel_ready = s_ready[idx_q];
    assign w_sel_rdata = s_rdata[32*idx_q +: 32];

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_addr_d = err_addr_q;
        w_err_set  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu.m_valid && w_in_win) begin
                    if (w_aligned) begin
                        idx_d   = w_idx;
                        addr_d  = cpu.m_addr;
                        wdata_d = cpu.m_wdata;
                        wstrb_d = cpu.m_wstrb;
                        cnt_d   = '0;
                        state_d = ST_ACCESS;
                    end else begin
                        rdata_d    = ERR_DATA;
                        w_err_set  = 1'b1;
                        err_addr_d = cpu.m_addr;
                        state_d    = ST_RESP;
                    end
                end
            end
            ST_ACCESS: begin
                // ready on the last permitted cycle takes priority over the watchdog
                if (w_sel_ready) begin
                    rdata_d = w_sel_rdata;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d    = ERR_DATA;
                    w_err_set  = 1'b1;
                    err_addr_d = addr_q;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        err_flag_d = w_err_set | (err_flag_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err_flag_q <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            err_flag_q <= err_flag_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign cpu.m_ready = (state_q == ST_RESP);
    assign cpu.m_rdata = rdata_q;
    assign s_sel       = (state_q == ST_ACCESS) ? (NUM_SLV'(1) << idx_q) : '0;
    assign s_addr      = addr_q;
    assign s_wdata     = wdata_q;
    assign s_wstrb     = (state_q == ST_ACCESS) ? wstrb_q : 4'd0;
    assign err_flag    = err_flag_q;
    assign err_addr    = err_addr_q;

endmodule
`default_nettype wire
